pipe_skid_reg: RTL and testbench

- Generic, parametrised pipeline stage register.
- Successor to the fixed per-stage latch interfaces: one module serves any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) by carrying a packed stage bundle of DATA_W bits.
- Adds a valid/ready handshake, synchronous flush with bubble insertion, and an optional 2-entry skid mode so that in_ready is registered.
- Also provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/pipe_skid_reg_if.sv | 32 +++
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_skid_reg.sv | 127 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by
// all pipeline bundles.
package cpu_types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/pipe_pkg.sv
// Stage-boundary bundles, their widths
// and the stage register state type.
package pipe_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } ifid_t;

  typedef struct packed {
    word_t      pc;
    word_t      rs1_val;
    word_t      rs2_val;
    word_t      imm;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
  } idex_t;

  typedef struct packed {
    word_t      alu_res;
    word_t      store_val;
    logic [4:0] rd;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
  } exmem_t;

  typedef struct packed {
    word_t      wb_val;
    logic [4:0] rd;
    logic       reg_wr;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // Held-entry count for a given state.
  function automatic logic [1:0] occ_of(
    pipe_state_t s
  );
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream and downstream valid/ready
// links of one stage register.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with
// synchronous clear over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] STEP = W'(1);
  localparam logic [W-1:0] TOP  = '1;

  // Clear wins; stop at all-ones, never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != TOP) begin
      count <= count + STEP;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic stage register: valid/ready,
// flush to bubble, optional 2-deep skid.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 64,
  parameter bit              SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int              CNT_W  = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               cnt_clr,
  pipe_skid_reg_if.slave     bus,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              rdy;
  logic              in_fire;
  logic              out_fire;
  logic              stall;

  // Skid mode keeps ready off the
  // downstream path; pass mode forwards it.
  always_comb begin
    rdy = 1'b0;
    if (SKID) begin
      rdy = (state_q != FULL);
    end else begin
      rdy = (state_q == EMPTY) | bus.out_ready;
    end
  end

  assign bus.in_ready  = nRST & rdy;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign occupancy     = occ_of(state_q);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign stall    = bus.in_valid & ~bus.in_ready
                  & ~flush & nRST;

  // Next state and payload moves; flush
  // drops everything, including in_fire.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            (in_fire && out_fire): begin
              main_d = bus.in_data;
            end
            (in_fire && !out_fire && SKID): begin
              state_d = FULL;
              skid_d  = bus.in_data;
            end
            (!in_fire && out_fire): begin
              state_d = EMPTY;
              main_d  = BUBBLE;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (cnt_clr),
    .inc   (stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg with
// a FIFO scoreboard on the skid instance.
module tb_pipe_skid_reg;

  logic CLK = 1'b0;
  logic nRST;
  logic flush;
  logic cnt_clr;

  always #5 CLK = ~CLK;

  pipe_skid_reg_if #(.DATA_W(32)) sk ();
  pipe_skid_reg_if #(.DATA_W(32)) ps ();
  pipe_skid_reg_if #(.DATA_W(8))  st ();

  logic [1:0]  sk_occ;
  logic [1:0]  ps_occ;
  logic [1:0]  st_occ;
  logic [31:0] sk_cnt;
  logic [31:0] ps_cnt;
  logic [2:0]  st_cnt;

  pipe_skid_reg #(
    .DATA_W (32),
    .SKID   (1'b1),
    .BUBBLE (32'h0),
    .CNT_W  (32)
  ) u_sk (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .bus       (sk),
    .occupancy (sk_occ),
    .stall_cnt (sk_cnt)
  );

  pipe_skid_reg #(
    .DATA_W (32),
    .SKID   (1'b0),
    .BUBBLE (32'h0),
    .CNT_W  (32)
  ) u_ps (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .bus       (ps),
    .occupancy (ps_occ),
    .stall_cnt (ps_cnt)
  );

  pipe_skid_reg #(
    .DATA_W (8),
    .SKID   (1'b1),
    .BUBBLE (8'h0),
    .CNT_W  (3)
  ) u_st (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .bus       (st),
    .occupancy (st_occ),
    .stall_cnt (st_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Every downstream transfer must match
  // the oldest beat the bench sent.
  always @(negedge CLK) begin
    if (sk.out_valid === 1'b1 &&
        sk.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL sb_extra: got %0h want none",
               sk.out_data);
      end else begin
        chk("sb_data", 64'(sk.out_data),
            64'(sb.pop_front()));
      end
    end
  end

  initial begin
    nRST = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    sk.in_valid = 1'b0;
    sk.in_data = '0;
    sk.out_ready = 1'b0;
    ps.in_valid = 1'b0;
    ps.in_data = '0;
    ps.out_ready = 1'b0;
    st.in_valid = 1'b0;
    st.in_data = '0;
    st.out_ready = 1'b0;

    step();
    step();
    chk("rst_in_ready_low", 64'(sk.in_ready), 0);
    nRST = 1'b1;
    #1;
    chk("rst_out_valid", 64'(sk.out_valid), 0);
    chk("rst_out_data", 64'(sk.out_data), 0);
    chk("rst_occ", 64'(sk_occ), 0);
    chk("rst_in_ready", 64'(sk.in_ready), 1);
    chk("rst_stall", 64'(sk_cnt), 0);

    sk.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sk.in_valid = 1'b1;
      sk.in_data = 32'(i);
      sb.push_back(32'(i));
      step();
      chk("stream_valid", 64'(sk.out_valid), 1);
      chk("stream_data", 64'(sk.out_data), 64'(i));
    end
    sk.in_valid = 1'b0;
    step();
    chk("stream_drain", 64'(sk.out_valid), 0);

    sk.out_ready = 1'b0;
    sk.in_valid = 1'b1;
    sk.in_data = 32'hA;
    sb.push_back(32'hA);
    step();
    chk("bp_occ1", 64'(sk_occ), 1);
    chk("bp_rdy1", 64'(sk.in_ready), 1);
    sk.in_data = 32'hB;
    sb.push_back(32'hB);
    step();
    chk("bp_occ2", 64'(sk_occ), 2);
    chk("bp_rdy2", 64'(sk.in_ready), 0);
    sk.in_data = 32'hD;
    for (int i = 0; i < 5; i++) step();
    chk("bp_stall5", 64'(sk_cnt), 5);
    chk("bp_hold_data", 64'(sk.out_data), 64'hA);
    chk("bp_hold_valid", 64'(sk.out_valid), 1);
    sk.out_ready = 1'b1;
    sb.push_back(32'hD);
    step();
    chk("bp_stall6", 64'(sk_cnt), 6);
    chk("bp_out_b", 64'(sk.out_data), 64'hB);
    step();
    chk("bp_out_d", 64'(sk.out_data), 64'hD);
    sk.in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(sk.out_valid), 0);

    sk.out_ready = 1'b0;
    sk.in_valid = 1'b1;
    sk.in_data = 32'hA;
    step();
    sk.in_data = 32'hB;
    step();
    chk("fl_full", 64'(sk_occ), 2);
    flush = 1'b1;
    sk.in_data = 32'hC;
    step();
    flush = 1'b0;
    sk.in_valid = 1'b0;
    #1;
    chk("fl_occ", 64'(sk_occ), 0);
    chk("fl_data", 64'(sk.out_data), 0);
    chk("fl_valid", 64'(sk.out_valid), 0);
    chk("fl_stall", 64'(sk_cnt), 6);
    sk.out_ready = 1'b1;
    step();
    step();
    chk("fl_no_c", 64'(sk.out_valid), 0);

    ps.out_ready = 1'b0;
    ps.in_valid = 1'b1;
    ps.in_data = 32'h11;
    step();
    chk("ps_rdy0", 64'(ps.in_ready), 0);
    ps.in_data = 32'h22;
    step();
    chk("ps_occ_a", 64'(ps_occ), 1);
    step();
    chk("ps_occ_b", 64'(ps_occ), 1);
    chk("ps_hold", 64'(ps.out_data), 64'h11);
    ps.out_ready = 1'b1;
    ps.in_data = 32'h33;
    #1;
    chk("ps_rdy1", 64'(ps.in_ready), 1);
    step();
    chk("ps_repl", 64'(ps.out_data), 64'h33);
    chk("ps_occ_c", 64'(ps_occ), 1);
    chk("ps_stall", 64'(ps_cnt), 2);
    ps.in_valid = 1'b0;
    step();
    chk("ps_empty", 64'(ps.out_valid), 0);

    st.out_ready = 1'b0;
    st.in_valid = 1'b1;
    st.in_data = 8'h1;
    step();
    st.in_data = 8'h2;
    step();
    chk("sat_full", 64'(st_occ), 2);
    for (int i = 0; i < 10; i++) step();
    chk("sat_top", 64'(st_cnt), 7);
    cnt_clr = 1'b1;
    step();
    chk("sat_clr", 64'(st_cnt), 0);
    cnt_clr = 1'b0;
    step();
    chk("sat_restart", 64'(st_cnt), 1);

    chk("sb_empty", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
